// File: rtl/operand_loader_pkg.sv
// Shared definitions for the serial operand loader:
// FSM state encoding and default operand width.
package operand_loader_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_X = 2'd1,
        LOAD_Y = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Handshake and operand bundle between the serial source,
// the operand loader and the downstream consumer.
interface operand_loader_if
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sdata;
    logic             sdata_valid;
    logic             ack;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             busy;
    logic [7:0]       frames;

    modport master (
        output start, sdata, sdata_valid, ack,
        input  x, y, valid, busy, frames
    );

    modport slave (
        input  start, sdata, sdata_valid, ack,
        output x, y, valid, busy, frames
    );
endinterface

// File: rtl/operand_loader_shift_in_reg.sv
// Serial-in parallel-out register; o_next is the value after
// the pending shift so a full word is visible on its last bit.
module shift_in_reg
    import operand_loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_next
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shift;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shift = {r_q[WIDTH-2:0], i_din};
        end else begin : g_lsb
            assign w_shift = {i_din, r_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_shift;
        end
    end

    assign o_q    = r_q;
    assign o_next = i_en ? w_shift : r_q;
endmodule

// File: rtl/operand_loader.sv
// Loads two serial operands and presents them together as a
// stable, registered pair until the consumer acknowledges.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    operand_loader_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             w_sh_x;
    logic             w_sh_y;
    logic             w_hold_entry;
    logic [WIDTH-1:0] w_xq;
    logic [WIDTH-1:0] w_xn;
    logic [WIDTH-1:0] w_yq;
    logic [WIDTH-1:0] w_yn;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic             r_busy;
    logic [7:0]       r_frames;

    shift_in_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sx (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_sh_x),
        .i_din  (bus.sdata),
        .o_q    (w_xq),
        .o_next (w_xn)
    );

    shift_in_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sy (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_sh_y),
        .i_din  (bus.sdata),
        .o_q    (w_yq),
        .o_next (w_yn)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_sh_x     = 1'b0;
        w_sh_y     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next     = LOAD_X;
                    w_cnt_next = '0;
                end
            end
            LOAD_X: begin
                if (bus.start) begin
                    w_next     = LOAD_X;
                    w_cnt_next = '0;
                end else if (bus.sdata_valid) begin
                    w_sh_x = 1'b1;
                    if (r_cnt == LAST) begin
                        w_next     = LOAD_Y;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            LOAD_Y: begin
                if (bus.start) begin
                    w_next     = LOAD_X;
                    w_cnt_next = '0;
                end else if (bus.sdata_valid) begin
                    w_sh_y = 1'b1;
                    if (r_cnt == LAST) begin
                        w_next     = HOLD;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    w_next     = bus.start ? LOAD_X : IDLE;
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // y takes the post-shift value: its last bit lands on this same edge
    assign w_hold_entry = (r_state == LOAD_Y) && (w_next == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_frames <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_valid <= (w_next == HOLD);
            r_busy  <= (w_next == LOAD_X) || (w_next == LOAD_Y);
            if (w_hold_entry) begin
                r_x      <= w_xq;
                r_y      <= w_yn;
                r_frames <= r_frames + 8'd1;
            end
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.valid  = r_valid;
    assign bus.busy   = r_busy;
    assign bus.frames = r_frames;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: nominal, gapped, abort,
// back-to-back, mid-load reset and frame counter wrap.
module tb_operand_loader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    operand_loader_if #(.WIDTH(8)) bus ();

    operand_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            bus.sdata_valid = 1'b0;
            bus.sdata       = ~b;
            tick();
        end
        bus.sdata       = b;
        bus.sdata_valid = 1'b1;
        tick();
        bus.sdata_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] xv, input logic [7:0] yv,
                             input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(xv[i], gap);
        for (int i = 7; i >= 0; i--) send_bit(yv[i], gap);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.sdata       = 1'b0;
        bus.sdata_valid = 1'b0;
        bus.ack         = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_x", 32'(bus.x), 32'h0);
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_frames", 32'(bus.frames), 32'h0);

        // sdata_valid and ack in IDLE do nothing
        bus.ack = 1'b1;
        send_bit(1'b1, 1'b0);
        bus.ack = 1'b0;
        chk("idle_busy", 32'(bus.busy), 32'h0);
        chk("idle_valid", 32'(bus.valid), 32'h0);

        // nominal load
        pulse_start();
        chk("nom_busy", 32'(bus.busy), 32'h1);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i), 1'b0);
        bus.ack = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hF0 >> i), 1'b0);
        bus.ack = 1'b0;
        chk("nom_pre_valid", 32'(bus.valid), 32'h0);
        send_bit(1'b0, 1'b0);
        chk("nom_x", 32'(bus.x), 32'hA5);
        chk("nom_y", 32'(bus.y), 32'hF0);
        chk("nom_valid", 32'(bus.valid), 32'h1);
        chk("nom_busy0", 32'(bus.busy), 32'h0);
        chk("nom_frames", 32'(bus.frames), 32'h1);

        // start and data without ack are ignored in HOLD
        bus.start = 1'b1;
        send_bit(1'b1, 1'b0);
        bus.start = 1'b0;
        chk("hold_valid", 32'(bus.valid), 32'h1);
        chk("hold_busy", 32'(bus.busy), 32'h0);
        chk("hold_x", 32'(bus.x), 32'hA5);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("ack_valid", 32'(bus.valid), 32'h0);
        chk("ack_busy", 32'(bus.busy), 32'h0);

        // gapped bits
        pulse_start();
        send_pair(8'hA5, 8'hF0, 1'b1);
        chk("gap_x", 32'(bus.x), 32'hA5);
        chk("gap_y", 32'(bus.y), 32'hF0);
        chk("gap_valid", 32'(bus.valid), 32'h1);
        chk("gap_frames", 32'(bus.frames), 32'h2);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // abort after 5 bits
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b0);
        chk("abort_hold_x", 32'(bus.x), 32'hA5);
        pulse_start();
        chk("abort_busy", 32'(bus.busy), 32'h1);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h3C >> i), 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hC3 >> i), 1'b0);
        chk("abort_pre_x", 32'(bus.x), 32'hA5);
        chk("abort_pre_y", 32'(bus.y), 32'hF0);
        send_bit(1'b1, 1'b0);
        chk("abort_x", 32'(bus.x), 32'h3C);
        chk("abort_y", 32'(bus.y), 32'hC3);
        chk("abort_frames", 32'(bus.frames), 32'h3);

        // back-to-back ack + start
        bus.ack   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        chk("b2b_valid", 32'(bus.valid), 32'h0);
        chk("b2b_busy", 32'(bus.busy), 32'h1);
        chk("b2b_x_held", 32'(bus.x), 32'h3C);
        send_pair(8'h12, 8'h34, 1'b0);
        chk("b2b_x", 32'(bus.x), 32'h12);
        chk("b2b_y", 32'(bus.y), 32'h34);
        chk("b2b_frames", 32'(bus.frames), 32'h4);

        // reset at bit 12
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        pulse_start();
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_x", 32'(bus.x), 32'h0);
        chk("mrst_y", 32'(bus.y), 32'h0);
        chk("mrst_valid", 32'(bus.valid), 32'h0);
        chk("mrst_busy", 32'(bus.busy), 32'h0);
        chk("mrst_frames", 32'(bus.frames), 32'h0);
        pulse_start();
        send_pair(8'h5A, 8'hC3, 1'b0);
        chk("post_x", 32'(bus.x), 32'h5A);
        chk("post_y", 32'(bus.y), 32'hC3);
        chk("post_frames", 32'(bus.frames), 32'h1);

        // 255 more pairs wrap the counter to 0
        for (int i = 0; i < 255; i++) begin
            bus.ack   = 1'b1;
            bus.start = 1'b1;
            tick();
            bus.ack   = 1'b0;
            bus.start = 1'b0;
            send_pair(8'(i), ~8'(i), 1'b0);
            if (i == 253) chk("wrap_255", 32'(bus.frames), 32'd255);
        end
        chk("wrap_0", 32'(bus.frames), 32'h0);
        chk("wrap_x", 32'(bus.x), 32'hFE);
        chk("wrap_y", 32'(bus.y), 32'h01);
        chk("wrap_valid", 32'(bus.valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
